io_trap_sequencer: RTL

IO_TRAP_SEQUENCER -- requirements
Module: io_trap_sequencer

---
 rtl/io_trap_sequencer_pkg.sv | 25 ++
 rtl/io_trap_sequencer_bus_sampler.sv | 38 +++
 rtl/io_trap_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/io_trap_sequencer_pkg.sv
// Shared definitions for the Z80 I/O trap sequencer: state encoding,
// parameter defaults and a saturating counter helper.
package io_trap_sequencer_pkg;

  localparam logic [7:0] TRAP_BASE_DEF  = 8'hA0;
  localparam logic [7:0] TRAP_MASK_DEF  = 8'hF0;
  localparam logic [3:0] NMI_CYCLES_DEF = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCESS = 3'd1,
    ST_ARM    = 3'd2,
    ST_NMI    = 3'd3,
    ST_HOLD   = 3'd4
  } trap_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return 8'hFF;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/io_trap_sequencer_bus_sampler.sv
// Single-stage registration of the Z80 bus strobes plus detection of the
// rising edge of the registered M1 strobe (end of an opcode fetch).
module bus_sampler (
  input  logic clk,
  input  logic reset,
  input  logic iorq_n,
  input  logic m1_n,
  input  logic rd_n,
  input  logic wr_n,
  output logic iorq_q,
  output logic m1_q,
  output logic rd_q,
  output logic wr_q,
  output logic m1_rise
);

  logic m1_prev_r;

  // Strobe sampling stage; idle bus level is all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iorq_q    <= 1'b1;
      m1_q      <= 1'b1;
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      m1_prev_r <= 1'b1;
    end else begin
      iorq_q    <= iorq_n;
      m1_q      <= m1_n;
      rd_q      <= rd_n;
      wr_q      <= wr_n;
      m1_prev_r <= m1_q;
    end
  end

  assign m1_rise = m1_q & ~m1_prev_r;

endmodule

// File: rtl/io_trap_sequencer.sv
// Traps I/O accesses to a configurable port window, flags the next opcode
// fetch for capture, then raises a timed NMI and waits for the handler's ack.
module io_trap_sequencer
  import io_trap_sequencer_pkg::*;
#(
  parameter logic [7:0] TRAP_BASE  = TRAP_BASE_DEF,
  parameter logic [7:0] TRAP_MASK  = TRAP_MASK_DEF,
  parameter logic [3:0] NMI_CYCLES = NMI_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic       iorq_n,
  input  logic       m1_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       trap_en,
  input  logic       trap_ack,
  output logic       record_isr,
  output logic       nmi_n,
  output logic [7:0] trap_port,
  output logic       trap_wr,
  output logic [7:0] trap_count,
  output logic       busy
);

  logic        iorq_q;
  logic        m1_q;
  logic        rd_q;
  logic        wr_q;
  logic        m1_rise_s;
  logic        hit_s;
  trap_state_t state_r;
  logic [3:0]  nmi_cnt_r;

  bus_sampler u_bus_sampler (
    .clk     (clk),
    .reset   (reset),
    .iorq_n  (iorq_n),
    .m1_n    (m1_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .iorq_q  (iorq_q),
    .m1_q    (m1_q),
    .rd_q    (rd_q),
    .wr_q    (wr_q),
    .m1_rise (m1_rise_s)
  );

  // Trap hit decode; requiring m1_q high excludes interrupt-acknowledge cycles.
  always_comb begin
    hit_s = 1'b0;
    if (trap_en && !iorq_q && m1_q && (!rd_q || !wr_q) &&
        ((addr & TRAP_MASK) == (TRAP_BASE & TRAP_MASK))) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Trap sequencing FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      nmi_cnt_r  <= 4'd0;
      record_isr <= 1'b0;
      nmi_n      <= 1'b1;
      trap_port  <= 8'h00;
      trap_wr    <= 1'b0;
      trap_count <= 8'h00;
      busy       <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hit_s) begin
            state_r    <= ST_ACCESS;
            busy       <= 1'b1;
            trap_port  <= addr;
            trap_wr    <= ~wr_q;
            trap_count <= sat_inc8(trap_count);
          end
        end
        ST_ACCESS: begin
          // Stay here until the I/O cycle ends so one cycle records one hit.
          if (!trap_en) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else if (iorq_q) begin
            state_r    <= ST_ARM;
            record_isr <= 1'b1;
          end
        end
        ST_ARM: begin
          if (!trap_en) begin
            state_r    <= ST_IDLE;
            busy       <= 1'b0;
            record_isr <= 1'b0;
          end else if (m1_rise_s) begin
            state_r    <= ST_NMI;
            record_isr <= 1'b0;
            nmi_n      <= 1'b0;
            nmi_cnt_r  <= NMI_CYCLES - 4'd1;
          end
        end
        ST_NMI: begin
          if (nmi_cnt_r == 4'd0) begin
            state_r <= ST_HOLD;
            nmi_n   <= 1'b1;
          end else begin
            nmi_cnt_r <= nmi_cnt_r - 4'd1;
          end
        end
        ST_HOLD: begin
          // Hits are not examined here, so one coinciding with the ack is dropped.
          if (trap_ack) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          nmi_cnt_r  <= 4'd0;
          record_isr <= 1'b0;
          nmi_n      <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
